// File: rtl/seg7_pkg.sv
// Shared constants and types for the seg7_scan_driver block.
// Segment patterns are ordered seg[0:6] = a..g, active-high.
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b1111110;
  localparam logic [0:6] SEG_1     = 7'b0110000;
  localparam logic [0:6] SEG_2     = 7'b1101101;
  localparam logic [0:6] SEG_3     = 7'b1111001;
  localparam logic [0:6] SEG_4     = 7'b0110011;
  localparam logic [0:6] SEG_5     = 7'b1011011;
  localparam logic [0:6] SEG_6     = 7'b1011111;
  localparam logic [0:6] SEG_7     = 7'b1110000;
  localparam logic [0:6] SEG_8     = 7'b1111111;
  localparam logic [0:6] SEG_9     = 7'b1111011;
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  typedef enum logic {GUARD, SHOW} state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: BCD/dp capture inputs,
// blanking control and the scanned segment/anode outputs.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = $clog2(DIGITS);

  logic [4*DIGITS-1:0] code;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                BI_L;
  logic [0:6]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   an_l;
  logic [IDX_W-1:0]    scan_idx;

  modport master (
    output code, dp, load, BI_L,
    input  seg, dp_out, an_l, scan_idx
  );

  modport slave (
    input  code, dp, load, BI_L,
    output seg, dp_out, an_l, scan_idx
  );
endinterface

// File: rtl/seg7_decode.sv
// BCD to 7-segment decoder; codes 10..15 and the blank request give all-off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [0:6] seg
);

  // Table lookup, forced dark when blanked
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with shadow register,
// guard interval between digit slots and global blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 1000,
  parameter int GUARD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int GCNT_W = $clog2(GUARD_CYC + 1);

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic [4*DIGITS-1:0] code_sh;
  logic [DIGITS-1:0]   dp_sh;
  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [GCNT_W-1:0]   gcnt, gcnt_nxt;
  logic [3:0]          digit;
  logic                dp_sel;
  logic                lz_blank;
  logic                blank;
  logic [0:6]          seg_dec;
  logic [0:6]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic [IDX_W-1:0]    idx_q;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  // Free-running slot prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Shadow capture; the display only ever reads the shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_sh <= '0;
      dp_sh   <= '0;
    end else if (bus.load) begin
      code_sh <= bus.code;
      dp_sh   <= bus.dp;
    end
  end

  // Scan FSM state, digit index and guard counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GUARD;
      idx   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  // Next state: a tick seen while in GUARD is dropped, so that slot runs to the next tick
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gcnt_nxt  = gcnt;
    case (state)
      GUARD: begin
        gcnt_nxt = gcnt + 1'b1;
        if (gcnt == GCNT_W'(GUARD_CYC - 1)) state_nxt = SHOW;
      end
      SHOW: begin
        if (tick) begin
          idx_nxt   = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
          gcnt_nxt  = '0;
          state_nxt = GUARD;
        end
      end
      default: state_nxt = GUARD;
    endcase
  end

  // Select the current digit's code and decimal point from the shadow
  always_comb begin
    digit  = '0;
    dp_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        digit  = code_sh[4*i +: 4];
        dp_sel = dp_sh[i];
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic zacc;

  // Blank digit i>0 when it and every more-significant digit are zero
  always_comb begin
    lz_blank = 1'b0;
    zacc     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zacc = zacc && (code_sh[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) lz_blank = zacc;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign blank = (state != SHOW) || !bus.BI_L || lz_blank;

  seg7_decode u_decode (
    .code  (digit),
    .blank (blank),
    .seg   (seg_dec)
  );

  // Registered pin drivers; anode stays off during GUARD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b0;
      an_q  <= '1;
      idx_q <= '0;
    end else begin
      seg_q <= seg_dec;
      dp_q  <= (state == SHOW) && bus.BI_L && dp_sel;
      an_q  <= (state == SHOW) ? ~(DIGITS'(1) << idx) : '1;
      idx_q <= idx;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp_out   = dp_q;
  assign bus.an_l     = an_q;
  assign bus.scan_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=8, GUARD_CYC=2.
// Cycle n counts rising edges since reset release; digit s is lit on
// outputs for n = 3 + 8*k + (0..5) where s = k mod 4.
module tb_seg7_scan_driver;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PB = 7'b0000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n = 0;
  int   checks = 0;
  int   passed = 0;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS    (4),
    .CLK_DIV   (8),
    .GUARD_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
  endtask

  // segs holds digit i's pattern at segs[7*i +: 7]
  task automatic advance(input int k, input logic [27:0] segs, input logic [3:0] dps,
                         input logic bl);
    int m, slot;
    logic on;
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      #1;
      n++;
      m    = n - 3;
      on   = (n >= 3) && ((m % 8) < 6);
      slot = (n >= 3) ? ((m / 8) % 4) : 0;
      chk("an_l", 32'(bus.an_l), on ? 32'(~(4'b0001 << slot) & 4'hF) : 32'hF);
      chk("seg", 32'(bus.seg), (on && bl) ? 32'(segs[7*slot +: 7]) : 32'h0);
      chk("dp_out", 32'(bus.dp_out), 32'(on && bl && dps[slot]));
      chk("scan_idx", 32'(bus.scan_idx), 32'(((n - 1) / 8) % 4));
    end
  endtask

  initial begin
    logic [27:0] s1234, s00a7, s0005, s5678, s9999, s0000;
    s1234 = {P1, P2, P3, P4};
    s5678 = {P5, P6, P7, P8};
    s9999 = {P9, P9, P9, P9};
`ifdef SEG7_LZB_EN
    s00a7 = {PB, PB, PB, P7};
    s0005 = {PB, PB, PB, P5};
    s0000 = {PB, PB, PB, P0};
`else
    s00a7 = {P0, P0, PB, P7};
    s0005 = {P0, P0, P0, P5};
    s0000 = {P0, P0, P0, P0};
`endif

    bus.code = 16'h1234;
    bus.dp   = 4'b0000;
    bus.load = 1'b1;
    bus.BI_L = 1'b1;

    // Reset values
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an_l", 32'(bus.an_l), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h0);
    chk("rst_dp_out", 32'(bus.dp_out), 32'h0);
    chk("rst_scan_idx", 32'(bus.scan_idx), 32'h0);
    rst = 1'b0;
    n   = 0;

    // 1234 captured on the first edge, one full frame plus wrap
    advance(1, s1234, 4'b0000, 1'b1);
    bus.load = 1'b0;
    advance(32, s1234, 4'b0000, 1'b1);

    // 00A7: code 10 decodes blank
    bus.code = 16'h00A7;
    bus.load = 1'b1;
    advance(1, s00a7, 4'b0000, 1'b1);
    bus.load = 1'b0;
    advance(31, s00a7, 4'b0000, 1'b1);

    // 0005: leading zeros
    bus.code = 16'h0005;
    bus.load = 1'b1;
    advance(1, s0005, 4'b0000, 1'b1);
    bus.load = 1'b0;
    advance(31, s0005, 4'b0000, 1'b1);

    // Blanked frame with a decimal point pending on digit 2
    bus.code = 16'h5678;
    bus.dp   = 4'b0100;
    bus.load = 1'b1;
    advance(1, s5678, 4'b0100, 1'b0);
    bus.load = 1'b0;
    bus.BI_L = 1'b0;
    advance(31, s5678, 4'b0100, 1'b0);

    // Unblanked: dp_out only in digit 2's slot
    bus.BI_L = 1'b1;
    advance(32, s5678, 4'b0100, 1'b1);

    // Load 9999 in the middle of digit 1's slot
    advance(12, s5678, 4'b0100, 1'b1);
    bus.code = 16'h9999;
    bus.load = 1'b1;
    advance(1, s5678, 4'b0100, 1'b1);
    bus.load = 1'b0;
    advance(19, s9999, 4'b0100, 1'b1);

    // Asynchronous reset while digit 0 is lit
    advance(3, s9999, 4'b0100, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_an_l", 32'(bus.an_l), 32'hF);
    chk("async_rst_seg", 32'(bus.seg), 32'h0);
    chk("async_rst_dp_out", 32'(bus.dp_out), 32'h0);
    chk("async_rst_scan_idx", 32'(bus.scan_idx), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
    advance(12, s0000, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
